// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard; x0 reads zero and is never busy.
// Optional write-through bypass on the read ports: define REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wb0_en,
  input  logic [AW-1:0]        wb0_addr,
  input  logic [XLEN-1:0]      wb0_data,
  input  logic                 wb1_en,
  input  logic [AW-1:0]        wb1_addr,
  input  logic [XLEN-1:0]      wb1_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  output logic [CW-1:0]        busy_cnt
);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]    r_busy_cnt;
  logic [NREGS-1:0] w_busy_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_wb0_we;
  logic             w_wb1_we;

  assign w_wb0_we = wb0_en && (wb0_addr != '0);
  assign w_wb1_we = wb1_en && (wb1_addr != '0);

  // wb1 is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wb0_we) r_mem[wb0_addr] <= wb0_data;
      if (w_wb1_we) r_mem[wb1_addr] <= wb1_data;
    end
  end

  // Ordering encodes priority: flush > issue-set > write-back-clear
  always_comb begin
    w_busy_next = r_busy;
    if (wb0_en) w_busy_next[wb0_addr] = 1'b0;
    if (wb1_en) w_busy_next[wb1_addr] = 1'b0;
    if (iss_en) w_busy_next[iss_addr] = 1'b1;
    w_busy_next[0] = 1'b0;
    if (flush) w_busy_next = '0;
  end

  always_comb begin
    w_cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_cnt_next = w_cnt_next + CW'(w_busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
    end
  end

  assign busy_cnt = r_busy_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   w_ra;
      logic [XLEN-1:0] w_rdata;
      logic            w_rbusy;

      assign w_ra = rd_addr[gi*AW +: AW];

      always_comb begin
        w_rdata = r_mem[w_ra];
        w_rbusy = r_busy[w_ra];
`ifdef REGFILE_SB_BYPASS_EN
        if (wb1_en && (wb1_addr == w_ra)) begin
          w_rdata = wb1_data;
          w_rbusy = iss_en && (iss_addr == w_ra);
        end else if (wb0_en && (wb0_addr == w_ra)) begin
          w_rdata = wb0_data;
          w_rbusy = iss_en && (iss_addr == w_ra);
        end
`endif
        if (w_ra == '0) begin
          w_rdata = '0;
          w_rbusy = 1'b0;
        end
      end

      assign rd_data[gi*XLEN +: XLEN] = w_rdata;
      assign rd_busy[gi]              = w_rbusy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default 32x32/2-port instance plus a 16x64/4-port instance.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb0_en, wb1_en, iss_en, flush;
  logic [4:0]  wb0_addr, wb1_addr, iss_addr;
  logic [31:0] wb0_data, wb1_data;
  logic [5:0]  busy_cnt;

  regfile_sb u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  logic [15:0]  s_rd_addr;
  logic [255:0] s_rd_data;
  logic [3:0]   s_rd_busy;
  logic         s_wb0_en, s_wb1_en, s_iss_en, s_flush;
  logic [3:0]   s_wb0_addr, s_wb1_addr, s_iss_addr;
  logic [63:0]  s_wb0_data, s_wb1_data;
  logic [4:0]   s_busy_cnt;

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(4)) u_dut16 (
    .clk(clk), .rst(rst), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wb0_en(s_wb0_en), .wb0_addr(s_wb0_addr), .wb0_data(s_wb0_data),
    .wb1_en(s_wb1_en), .wb1_addr(s_wb1_addr), .wb1_data(s_wb1_data),
    .iss_en(s_iss_en), .iss_addr(s_iss_addr), .flush(s_flush), .busy_cnt(s_busy_cnt)
  );

  // kind: 0 main rd_data, 1 main rd_busy, 2 main busy_cnt, 3 sweep rd_data, 4 sweep busy_cnt
  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [4:0]  addr;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic push_exp(input string tag, input int kind, input int port,
                          input logic [4:0] addr, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.addr = addr; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0: begin
          rd_addr[e.port*5 +: 5] = e.addr; #1;
          check_val(e.tag, 64'(rd_data[e.port*32 +: 32]), e.exp);
        end
        1: begin
          rd_addr[e.port*5 +: 5] = e.addr; #1;
          check_val(e.tag, 64'(rd_busy[e.port]), e.exp);
        end
        2: check_val(e.tag, 64'(busy_cnt), e.exp);
        3: check_val(e.tag, s_rd_data[e.port*64 +: 64], e.exp);
        default: check_val(e.tag, 64'(s_busy_cnt), e.exp);
      endcase
    end
  endtask

  task automatic idle();
    wb0_en = 0; wb1_en = 0; iss_en = 0; flush = 0;
    s_wb0_en = 0; s_wb1_en = 0; s_iss_en = 0; s_flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    rst = 1; rd_addr = '0; s_rd_addr = {4'd0, 4'd15, 4'd2, 4'd1};
    wb0_addr = '0; wb1_addr = '0; iss_addr = '0; wb0_data = '0; wb1_data = '0;
    s_wb0_addr = '0; s_wb1_addr = '0; s_iss_addr = '0; s_wb0_data = '0; s_wb1_data = '0;
    idle();
    tick(); tick();
    rst = 0;
    push_exp("init_cnt", 2, 0, 0, 0);
    push_exp("init_x5", 0, 0, 5, 0);
    drain();

    // Reset clears contents and overrides concurrent write/issue
    wb0_en = 1; wb0_addr = 5; wb0_data = 32'hDEADBEEF; tick();
    push_exp("wr_x5", 0, 0, 5, 64'hDEADBEEF); drain();
    rst = 1; wb1_en = 1; wb1_addr = 6; wb1_data = 32'h66; iss_en = 1; iss_addr = 5; tick();
    rst = 0;
    push_exp("rst_x5", 0, 1, 5, 0);
    push_exp("rst_x6", 0, 0, 6, 0);
    push_exp("rst_busy5", 1, 0, 5, 0);
    push_exp("rst_cnt", 2, 0, 0, 0);
    drain();

    // Write-port collisions and x0
    wb0_en = 1; wb0_addr = 7; wb0_data = 32'h11; wb1_en = 1; wb1_addr = 7; wb1_data = 32'h22; tick();
    push_exp("coll_x7", 0, 0, 7, 64'h22); drain();
    wb0_en = 1; wb0_addr = 0; wb0_data = 32'hFFFF; wb1_en = 1; wb1_addr = 8; wb1_data = 32'h88; tick();
    push_exp("wr_x0", 0, 0, 0, 0);
    push_exp("wr_x8", 0, 1, 8, 64'h88);
    drain();
    wb0_en = 1; wb0_addr = 9; wb0_data = 32'h99; wb1_en = 1; wb1_addr = 10; wb1_data = 32'hAA; tick();
    push_exp("dual_x9", 0, 0, 9, 64'h99);
    push_exp("dual_x10", 0, 1, 10, 64'hAA);
    drain();

    // Same-cycle read during a write
    wb0_en = 1; wb0_addr = 3; wb0_data = 32'h12345678; tick();
    wb0_en = 1; wb0_addr = 3; wb0_data = 32'hA5A5A5A5;
`ifdef REGFILE_SB_BYPASS_EN
    push_exp("byp_same", 0, 0, 3, 64'hA5A5A5A5);
`else
    push_exp("byp_same", 0, 0, 3, 64'h12345678);
`endif
    drain();
    tick();
    push_exp("byp_next", 0, 0, 3, 64'hA5A5A5A5); drain();

    // Scoreboard set / set-wins / clear
    iss_en = 1; iss_addr = 4; tick();
    push_exp("iss_busy4", 1, 0, 4, 1);
    push_exp("iss_cnt", 2, 0, 0, 1);
    drain();
    wb0_en = 1; wb0_addr = 4; wb0_data = 32'h44; iss_en = 1; iss_addr = 4; tick();
    push_exp("setwin_busy4", 1, 1, 4, 1);
    push_exp("setwin_cnt", 2, 0, 0, 1);
    drain();
    wb1_en = 1; wb1_addr = 4; wb1_data = 32'h45;
`ifdef REGFILE_SB_BYPASS_EN
    push_exp("clr_same_busy4", 1, 0, 4, 0);
`else
    push_exp("clr_same_busy4", 1, 0, 4, 1);
`endif
    drain();
    tick();
    push_exp("clr_busy4", 1, 0, 4, 0);
    push_exp("clr_cnt", 2, 0, 0, 0);
    push_exp("clr_x4", 0, 1, 4, 64'h45);
    drain();
    iss_en = 1; iss_addr = 0; tick();
    push_exp("iss_x0_cnt", 2, 0, 0, 0); drain();

    // Flush beats same-cycle issue; write-back data still lands
    iss_en = 1; iss_addr = 1; tick();
    iss_en = 1; iss_addr = 2; tick();
    iss_en = 1; iss_addr = 3; tick();
    push_exp("pre_flush_cnt", 2, 0, 0, 3); drain();
    flush = 1; iss_en = 1; iss_addr = 9; wb0_en = 1; wb0_addr = 1; wb0_data = 32'h55; tick();
    push_exp("flush_cnt", 2, 0, 0, 0);
    push_exp("flush_busy9", 1, 0, 9, 0);
    push_exp("flush_x1", 0, 1, 1, 64'h55);
    drain();

    // Parameter sweep instance: 16 regs, 4 ports, 64-bit
    s_wb0_en = 1; s_wb0_addr = 1; s_wb0_data = 64'd1;
    s_wb1_en = 1; s_wb1_addr = 2; s_wb1_data = 64'd2; tick();
    s_wb0_en = 1; s_wb0_addr = 15; s_wb0_data = '1;
    s_wb1_en = 1; s_wb1_addr = 0; s_wb1_data = 64'h1234; tick();
    push_exp("sw_p0_x1", 3, 0, 0, 64'd1);
    push_exp("sw_p1_x2", 3, 1, 0, 64'd2);
    push_exp("sw_p2_x15", 3, 2, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    push_exp("sw_p3_x0", 3, 3, 0, 64'd0);
    drain();
    for (int r = 1; r < 16; r++) begin
      s_iss_en = 1; s_iss_addr = 4'(r); tick();
    end
    push_exp("sw_cnt_full", 4, 0, 0, 15); drain();
    s_flush = 1; tick();
    push_exp("sw_cnt_flush", 4, 0, 0, 0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register busy scoreboard for the pipelined CPU core. It provides NRD combinational read ports and two prioritised write-back ports, and register 0 is hard-wired to zero. A busy bit is set when an instruction issues to a destination and cleared when that destination is written back. Decode uses it to detect RAW hazards; the count of in-flight destinations goes to stall/flush control.

## Interface
Parameters:
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers; power of two, ≥4. AW = $clog2(NREGS).
- NRD, 2: number of read ports, 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rd_busy  out  NRD  port i's register has a pending write.
- wb0_en, wb1_en  in  1 each  write-back enables; port 1 is the younger/priority port.
- wb0_addr, wb1_addr  in  AW each  write-back destinations.
- wb0_data, wb1_data  in  XLEN each  write-back data.
- iss_en  in  1  an instruction with a destination issues this cycle.
- iss_addr  in  AW  issuing destination.
- flush  in  1  clear all busy bits; register contents kept.
- busy_cnt  out  $clog2(NREGS+1)  number of set busy bits.

## Operation
- Storage: NREGS×XLEN array plus NREGS-bit busy vector. Register 0 always reads 0, never stores, and is never busy. Writes, issues and busy to address 0 are ignored.
- Write: on a clk edge with wbX_en, reg[wbX_addr] ← wbX_data.
  - Both ports to the same nonzero address: wb1 data is stored.
  - Different addresses: both are stored.
- Busy set: iss_en with nonzero iss_addr sets busy[iss_addr] at the next edge.
- Busy clear: wbX_en clears busy[wbX_addr] at the next edge.
  - If the same cycle has an issue to the same address, set wins; the new producer is pending.
- Flush: clears every busy bit at the next edge.
  - Overrides same-cycle issue and write-back clears.
  - Same-cycle write-back data is still stored.
- Priority, highest first: rst > flush > issue-set > write-back-clear.
- Reads are combinational from rd_addr.
  - rd_data: value as defined by the configuration section.
  - rd_busy: busy bit of the addressed register, subject to bypass (see Configuration).
- busy_cnt: registered; always equals popcount(busy) in the same cycle. No overflow is possible.

## Timing
- Reset (rst high at an edge): all registers = 0, busy = 0, busy_cnt = 0.
  - rst overrides any concurrent write, issue or flush.
  - Outputs reflect the reset state from the cycle after the edge. rd_data of any address is then 0.
- Write latency: 1 edge into storage. Read-after-write through storage: data is visible the cycle after the write edge.
- Issue → rd_busy high: the cycle after the iss_en edge.
- Write-back → rd_busy low:
  - With bypass: the same cycle.
  - Without bypass: the cycle after the edge.
- busy_cnt updates on the same edge as the busy vector.
- No handshakes: every enable is single-cycle and accepted unconditionally.

## Configuration
- Macro REGFILE_SB_BYPASS_EN.
- Defined (write-through bypass):
  - Read of nonzero address A while wbX_en && wbX_addr == A returns that write data; wb1 wins if both match.
  - rd_busy for A is 0 that cycle unless iss_en && iss_addr == A.
- Undefined:
  - rd_data comes only from stored contents (pre-write value in the write cycle).
  - rd_busy is the raw stored busy bit.
  - No combinational path from wb*/iss* to rd_*.

## Test plan
- Reset: write x5=0xDEADBEEF, assert rst one cycle → next cycle rd x5 = 0, busy_cnt = 0, rd_busy = 0.
- Dual-write collision: wb0 x7=0x11, wb1 x7=0x22 in the same cycle → next cycle rd x7 = 0x22. Write to x0=0xFFFF → rd x0 = 0.
- Bypass (macro defined): rd_addr0=3 while wb0 x3=0xA5A5A5A5 → rd_data0 = 0xA5A5A5A5 the same cycle. Macro undefined → old value that cycle, 0xA5A5A5A5 the next.
- Scoreboard:
  - Issue x4 → next cycle rd_busy = 1, busy_cnt = 1.
  - wb x4 plus issue x4 in the same cycle → still busy, busy_cnt = 1.
  - wb x4 alone → busy clears, busy_cnt = 0.
- Flush: issue x1, x2, x3 on consecutive cycles (busy_cnt = 3), then flush with a same-cycle issue x9 and wb x1=0x55 → busy_cnt = 0, x9 not busy, rd x1 = 0x55.
- Parameter sweep: NREGS=16, NRD=4, XLEN=64. Four ports read x1, x2, x15, x0 after writing 1, 2, 0xF…F → values 1, 2, all-ones, 0.
